// File: rtl/operand_fetch.sv
// Decode and register-read stage ahead of the ALU: owns the 32x32 register file,
// bypasses same-cycle write-back, and presents ALU operands from one output register.
module operand_fetch #(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   instr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] data1,
  output logic [DW-1:0] data2,
  output logic [4:0]    shamt,
  output logic [5:0]    funct,
  output logic [4:0]    rd_addr,
  output logic          rd_we,
  output logic          illegal,
  input  logic          wb_en,
  input  logic [4:0]    wb_addr,
  input  logic [DW-1:0] wb_data
);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpSlti  = 6'b101010;
  localparam logic [5:0] FnAddu  = 6'b001001;
  localparam logic [5:0] FnSubu  = 6'b001010;
  localparam logic [5:0] FnSll   = 6'b100001;
  localparam logic [5:0] FnSllv  = 6'b110101;

  logic [5:0] op, fn;
  logic [4:0] rs, rt, rd, sh;
  logic [15:0] imm;

  assign op  = instr[31:26];
  assign rs  = instr[25:21];
  assign rt  = instr[20:16];
  assign rd  = instr[15:11];
  assign sh  = instr[10:6];
  assign fn  = instr[5:0];
  assign imm = instr[15:0];

  // Register file
  logic [DW-1:0] rf_q [32];
  logic [DW-1:0] rf_d [32];
  logic          wb_hit;

  assign wb_hit = wb_en && (wb_addr != 5'd0);

  always_comb begin
    rf_d = rf_q;
    if (wb_hit) rf_d[wb_addr] = wb_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  // Read ports with write-back bypass; R0 is hardwired to zero
  logic [DW-1:0] rs_val, rt_val;

  always_comb begin
    if (rs == 5'd0)                   rs_val = '0;
    else if (wb_hit && wb_addr == rs) rs_val = wb_data;
    else                              rs_val = rf_q[rs];
  end

  always_comb begin
    if (rt == 5'd0)                   rt_val = '0;
    else if (wb_hit && wb_addr == rt) rt_val = wb_data;
    else                              rt_val = rf_q[rt];
  end

  // Decode
  logic [DW-1:0] dec_d1, dec_d2;
  logic [4:0]    dec_sh, dec_rd;
  logic [5:0]    dec_fn;
  logic          dec_ill;

  always_comb begin
    dec_d1  = '0;
    dec_d2  = '0;
    dec_sh  = 5'd0;
    dec_fn  = 6'd0;
    dec_rd  = 5'd0;
    dec_ill = 1'b0;
    if (op == OpRtype && (fn == FnAddu || fn == FnSubu)) begin
      dec_d1 = rs_val;
      dec_d2 = rt_val;
      dec_sh = sh;
      dec_fn = fn;
      dec_rd = rd;
    end else if (op == OpRtype && fn == FnSll) begin
      dec_d1 = rt_val;
      dec_sh = sh;
      dec_fn = fn;
      dec_rd = rd;
    end else if (op == OpRtype && fn == FnSllv) begin
      dec_d1 = rt_val;
      dec_d2 = rs_val;
      dec_sh = sh;
      dec_fn = fn;
      dec_rd = rd;
    end else if (op == OpSlti) begin
      dec_d1 = rs_val;
      dec_d2 = {{(DW-16){imm[15]}}, imm};
      dec_fn = OpSlti;
      dec_rd = rt;
    end else begin
      dec_ill = 1'b1;
    end
  end

  // Output pipeline register
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] data1_q, data1_d, data2_q, data2_d;
  logic [4:0]    shamt_q, shamt_d, rd_addr_q, rd_addr_d;
  logic [5:0]    funct_q, funct_d;
  logic          rd_we_q, rd_we_d, illegal_q, illegal_d;
  logic          accept;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    data1_d     = data1_q;
    data2_d     = data2_q;
    shamt_d     = shamt_q;
    funct_d     = funct_q;
    rd_addr_d   = rd_addr_q;
    rd_we_d     = rd_we_q;
    illegal_d   = illegal_q;
    if (accept) begin
      out_valid_d = 1'b1;
      data1_d     = dec_d1;
      data2_d     = dec_d2;
      shamt_d     = dec_sh;
      funct_d     = dec_fn;
      rd_addr_d   = dec_rd;
      rd_we_d     = !dec_ill && (dec_rd != 5'd0);
      illegal_d   = dec_ill;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      data1_q     <= '0;
      data2_q     <= '0;
      shamt_q     <= 5'd0;
      funct_q     <= 6'd0;
      rd_addr_q   <= 5'd0;
      rd_we_q     <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      data1_q     <= data1_d;
      data2_q     <= data2_d;
      shamt_q     <= shamt_d;
      funct_q     <= funct_d;
      rd_addr_q   <= rd_addr_d;
      rd_we_q     <= rd_we_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = out_valid_q;
  assign data1     = data1_q;
  assign data2     = data2_q;
  assign shamt     = shamt_q;
  assign funct     = funct_q;
  assign rd_addr   = rd_addr_q;
  assign rd_we     = rd_we_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios plus randomized traffic against a
// behavioural register-file/decode model.
module tb_operand_fetch;

  logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr, data1, data2, wb_data;
  logic [4:0]  shamt, rd_addr, wb_addr;
  logic [5:0]  funct;
  logic        rd_we, illegal, wb_en;

  operand_fetch #(.DW(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready), .data1(data1), .data2(data2),
    .shamt(shamt), .funct(funct), .rd_addr(rd_addr), .rd_we(rd_we), .illegal(illegal),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d1;
    logic [31:0] d2;
    logic [4:0]  sh;
    logic [5:0]  fn;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model_rf [32];
  logic        m_valid;
  exp_t        m_out;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic exp_t mk(input logic [31:0] d1, input logic [31:0] d2,
                              input logic [4:0] sh, input logic [5:0] fn,
                              input logic [4:0] rd, input logic we, input logic ill);
    exp_t e;
    e.d1 = d1; e.d2 = d2; e.sh = sh; e.fn = fn; e.rd = rd; e.we = we; e.ill = ill;
    return e;
  endfunction

  function automatic exp_t dut_out();
    return {data1, data2, shamt, funct, rd_addr, rd_we, illegal};
  endfunction

  // Architectural read as seen this cycle, including the write-back in flight
  function automatic logic [31:0] rv(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (wb_en && wb_addr == idx) return wb_data;
    return model_rf[idx];
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] ins);
    exp_t       e;
    logic [5:0] op, fn;
    logic [4:0] rs, rt;
    op = ins[31:26]; fn = ins[5:0]; rs = ins[25:21]; rt = ins[20:16];
    e = '0;
    if (op == 6'd0 && (fn == 6'b001001 || fn == 6'b001010)) begin
      e.d1 = rv(rs); e.d2 = rv(rt); e.sh = ins[10:6]; e.fn = fn; e.rd = ins[15:11];
    end else if (op == 6'd0 && fn == 6'b100001) begin
      e.d1 = rv(rt); e.sh = ins[10:6]; e.fn = fn; e.rd = ins[15:11];
    end else if (op == 6'd0 && fn == 6'b110101) begin
      e.d1 = rv(rt); e.d2 = rv(rs); e.sh = ins[10:6]; e.fn = fn; e.rd = ins[15:11];
    end else if (op == 6'b101010) begin
      e.d1 = rv(rs); e.d2 = 32'(signed'(ins[15:0])); e.fn = 6'b101010; e.rd = rt;
    end else begin
      e.ill = 1'b1;
    end
    e.we = !e.ill && (e.rd != 5'd0);
    return e;
  endfunction

  // Advance model and DUT by one clock using the currently driven inputs
  task automatic step();
    logic rdy;
    rdy = !m_valid || out_ready;
    if (in_valid && rdy) begin
      m_out   = ref_decode(instr);
      m_valid = 1'b1;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    if (wb_en && wb_addr != 5'd0) model_rf[wb_addr] = wb_data;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t want;
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_AAAA;
    in_valid = 1'b1; out_ready = 1'b0; instr = itype(6'b101010, 5'd0, 5'd5, 16'h1234);
    step();
    wb_en = 1'b0; in_valid = 1'b0;
    step();
    want = mk(32'd0, 32'h1234, 5'd0, 6'b101010, 5'd5, 1'b1, 1'b0);
    vectors++;
    if (out_valid !== 1'b1 || dut_out() !== want) begin
      miscompares++;
      $display("FAIL pre_reset_hold: got v=%b %h want v=1 %h", out_valid, dut_out(), want);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({out_valid, dut_out()} !== 83'd0) begin
      miscompares++;
      $display("FAIL async_reset_outputs: got v=%b %h want all zero", out_valid, dut_out());
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    foreach (model_rf[i]) model_rf[i] = 32'd0;
    m_valid = 1'b0; m_out = '0;
    // A write presented while reset is held must be lost
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h5555_5555;
    @(posedge clk);
    #1;
    rst_n = 1'b1; wb_en = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1; instr = rtype(5'd5, 5'd5, 5'd3, 5'd0, 6'b001010);
    step();
    want = mk(32'd0, 32'd0, 5'd0, 6'b001010, 5'd3, 1'b1, 1'b0);
    vectors++;
    if (out_valid !== 1'b1 || dut_out() !== want) begin
      miscompares++;
      $display("FAIL post_reset_r5: got v=%b %h want v=1 %h", out_valid, dut_out(), want);
    end
    in_valid = 1'b0;
    step();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL consume_clears: got %b want 0", out_valid);
    end
  endtask

  task automatic test_write_read();
    exp_t want;
    out_ready = 1'b1; in_valid = 1'b0;
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h10;
    step();
    wb_addr = 5'd4; wb_data = 32'h3;
    step();
    wb_en = 1'b0; in_valid = 1'b1; instr = rtype(5'd3, 5'd4, 5'd7, 5'd0, 6'b001001);
    step();
    want = mk(32'h10, 32'h3, 5'd0, 6'b001001, 5'd7, 1'b1, 1'b0);
    vectors++;
    if (out_valid !== 1'b1 || dut_out() !== want) begin
      miscompares++;
      $display("FAIL addu_read: got v=%b %h want v=1 %h", out_valid, dut_out(), want);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_bypass();
    exp_t want;
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'hDEAD_BEEF;
    in_valid = 1'b1; instr = rtype(5'd9, 5'd0, 5'd1, 5'd0, 6'b001010);
    step();
    want = mk(32'hDEAD_BEEF, 32'd0, 5'd0, 6'b001010, 5'd1, 1'b1, 1'b0);
    vectors++;
    if (dut_out() !== want) begin
      miscompares++;
      $display("FAIL bypass_subu: got %h want %h", dut_out(), want);
    end
    wb_en = 1'b0; instr = rtype(5'd0, 5'd9, 5'd2, 5'd0, 6'b001010);
    step();
    want = mk(32'd0, 32'hDEAD_BEEF, 5'd0, 6'b001010, 5'd2, 1'b1, 1'b0);
    vectors++;
    if (dut_out() !== want) begin
      miscompares++;
      $display("FAIL bypass_persist: got %h want %h", dut_out(), want);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_shift();
    exp_t want;
    wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'h1;
    step();
    wb_addr = 5'd6; wb_data = 32'h4;
    step();
    wb_en = 1'b0; in_valid = 1'b1; instr = rtype(5'd6, 5'd2, 5'd8, 5'd3, 6'b110101);
    step();
    want = mk(32'h1, 32'h4, 5'd3, 6'b110101, 5'd8, 1'b1, 1'b0);
    vectors++;
    if (dut_out() !== want) begin
      miscompares++;
      $display("FAIL sllv_map: got %h want %h", dut_out(), want);
    end
    instr = rtype(5'd7, 5'd2, 5'd9, 5'd31, 6'b100001);
    step();
    want = mk(32'h1, 32'd0, 5'd31, 6'b100001, 5'd9, 1'b1, 1'b0);
    vectors++;
    if (dut_out() !== want) begin
      miscompares++;
      $display("FAIL sll_map: got %h want %h", dut_out(), want);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_slti_illegal();
    exp_t want;
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h7;
    step();
    wb_en = 1'b0; in_valid = 1'b1; instr = itype(6'b101010, 5'd1, 5'd0, 16'h8000);
    step();
    want = mk(32'h7, 32'hFFFF_8000, 5'd0, 6'b101010, 5'd0, 1'b0, 1'b0);
    vectors++;
    if (dut_out() !== want) begin
      miscompares++;
      $display("FAIL slti_sext: got %h want %h", dut_out(), want);
    end
    instr = {6'b000010, 26'h3FF_FFFF};
    step();
    want = mk(32'd0, 32'd0, 5'd0, 6'd0, 5'd0, 1'b0, 1'b1);
    vectors++;
    if (dut_out() !== want) begin
      miscompares++;
      $display("FAIL illegal_op: got %h want %h", dut_out(), want);
    end
    instr = rtype(5'd3, 5'd4, 5'd7, 5'd5, 6'b100000);
    step();
    vectors++;
    if (dut_out() !== want) begin
      miscompares++;
      $display("FAIL illegal_fn: got %h want %h", dut_out(), want);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    exp_t wa, wb, wc;
    wa = mk(32'h10, 32'h3, 5'd0, 6'b001001, 5'd10, 1'b1, 1'b0);
    wb = mk(32'h10, 32'h3, 5'd0, 6'b001010, 5'd11, 1'b1, 1'b0);
    wc = mk(32'h10, 32'h3, 5'd2, 6'b110101, 5'd12, 1'b1, 1'b0);
    out_ready = 1'b0; in_valid = 1'b1; instr = rtype(5'd3, 5'd4, 5'd10, 5'd0, 6'b001001);
    step();
    instr = rtype(5'd3, 5'd4, 5'd11, 5'd0, 6'b001010);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_in_ready[%0d]: got %b want 0", i, in_ready);
      end
      step();
      vectors++;
      if (out_valid !== 1'b1 || dut_out() !== wa) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got v=%b %h want v=1 %h", i, out_valid, dut_out(), wa);
      end
    end
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL release_in_ready: got %b want 1", in_ready);
    end
    step();
    vectors++;
    if (out_valid !== 1'b1 || dut_out() !== wb) begin
      miscompares++;
      $display("FAIL b2b_second: got v=%b %h want v=1 %h", out_valid, dut_out(), wb);
    end
    instr = rtype(5'd4, 5'd3, 5'd12, 5'd2, 6'b110101);
    step();
    vectors++;
    if (out_valid !== 1'b1 || dut_out() !== wc) begin
      miscompares++;
      $display("FAIL b2b_third: got v=%b %h want v=1 %h", out_valid, dut_out(), wc);
    end
    in_valid = 1'b0;
    step();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_drain: got %b want 0", out_valid);
    end
  endtask

  task automatic test_random();
    logic [5:0] fns [4];
    fns[0] = 6'b001001; fns[1] = 6'b001010; fns[2] = 6'b100001; fns[3] = 6'b110101;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 5))
        0, 1, 2, 3: instr = rtype(5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                                  fns[$urandom_range(0, 3)]);
        4:       instr = itype(6'b101010, 5'($urandom), 5'($urandom), 16'($urandom));
        default: instr = $urandom;
      endcase
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      wb_en     = $urandom_range(0, 1) == 1;
      wb_addr   = 5'($urandom);
      wb_data   = $urandom;
      #1;
      vectors++;
      if (in_ready !== (!m_valid || out_ready)) begin
        miscompares++;
        $display("FAIL rand_in_ready[%0d]: got %b want %b", n, in_ready, !m_valid || out_ready);
      end
      step();
      vectors++;
      if (out_valid !== m_valid) begin
        miscompares++;
        $display("FAIL rand_valid[%0d]: got %b want %b", n, out_valid, m_valid);
      end
      if (m_valid) begin
        vectors++;
        if (dut_out() !== m_out) begin
          miscompares++;
          $display("FAIL rand_out[%0d]: got %h want %h", n, dut_out(), m_out);
        end
      end
    end
    in_valid = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
    step();
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; in_valid = 1'b0; instr = 32'd0; out_ready = 1'b0;
    wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    foreach (model_rf[i]) model_rf[i] = 32'd0;
    m_valid = 1'b0; m_out = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_write_read();
    test_bypass();
    test_shift();
    test_slti_illegal();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
